// File: rtl/avr_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// status bit positions and transmit FSM encoding.
package avr_io_pkg;

  localparam logic [1:0] UDR_OFS   = 2'd0;
  localparam logic [1:0] USR_OFS   = 2'd1;
  localparam logic [1:0] UBRRL_OFS = 2'd2;
  localparam logic [1:0] UBRRH_OFS = 2'd3;

  localparam int USR_EMPTY_BIT = 0;
  localparam int USR_FULL_BIT  = 1;
  localparam int USR_BUSY_BIT  = 2;
  localparam int USR_OVR_BIT   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/avr_sync_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two so the pointers
// wrap naturally. Synchronous reset flushes the contents.
module avr_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [DATA_W-1:0]         i_wr_data,
  input  logic                      i_pop,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);
  import avr_io_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_FULL);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/avr_io_uart.sv
// 8N1 UART transmitter sitting on the AVR data bus next to data memory.
// Four-byte register window, TX FIFO, and a one-cycle registered read port.
module avr_io_uart
  import avr_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h002C,
  parameter logic [15:0] CLK_DIV    = 16'd86,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] d_addr,
  input  logic        data_write,
  input  logic [7:0]  wdata,
  output logic [7:0]  io_rdata,
  output logic        io_hit,
  output logic        txd,
  output logic        tx_irq
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  logic [15:0]      w_off;
  logic             w_in_win;
  logic [1:0]       w_ofs;
  logic             w_wr_udr;
  logic             w_wr_usr;
  logic             w_wr_ubrrl;
  logic             w_wr_ubrrh;
  logic             w_push;
  logic             w_pop;
  logic             w_bit_end;
  logic [15:0]      w_ubrr;
  logic [7:0]       w_usr;
  logic [7:0]       w_rd_mux;
  logic [7:0]       w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [FIFO_AW:0] w_fifo_count;

  logic [7:0]       r_udr;
  logic             r_ovr;
  logic [7:0]       r_ubrrl;
  logic [7:0]       r_ubrrh;
  logic [7:0]       r_rdata;
  logic             r_hit;

  tx_state_e        r_state;
  logic             r_txd;
  logic [7:0]       r_shift;
  logic [15:0]      r_cnt;
  logic [15:0]      r_bit_div;
  logic [2:0]       r_idx;

  // Unsigned offset: addresses below the base wrap to large values and miss.
  assign w_off    = d_addr - BASE_ADDR;
  assign w_in_win = (w_off < 16'd4);
  assign w_ofs    = w_off[1:0];

  assign w_wr_udr   = data_write && w_in_win && (w_ofs == UDR_OFS);
  assign w_wr_usr   = data_write && w_in_win && (w_ofs == USR_OFS);
  assign w_wr_ubrrl = data_write && w_in_win && (w_ofs == UBRRL_OFS);
  assign w_wr_ubrrh = data_write && w_in_win && (w_ofs == UBRRH_OFS);

  assign w_ubrr    = {r_ubrrh, r_ubrrl};
  assign w_push    = w_wr_udr && !w_fifo_full;
  assign w_bit_end = (r_cnt == 16'd0);
  assign w_pop     = !w_fifo_empty &&
                     ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end));

  always_comb begin
    w_usr                = 8'h00;
    w_usr[USR_EMPTY_BIT] = w_fifo_empty;
    w_usr[USR_FULL_BIT]  = w_fifo_full;
    w_usr[USR_BUSY_BIT]  = (r_state != TX_IDLE);
    w_usr[USR_OVR_BIT]   = r_ovr;
  end

  always_comb begin
    w_rd_mux = 8'h00;
    case (w_ofs)
      UDR_OFS:   w_rd_mux = r_udr;
      USR_OFS:   w_rd_mux = w_usr;
      UBRRL_OFS: w_rd_mux = r_ubrrl;
      UBRRH_OFS: w_rd_mux = r_ubrrh;
      default:   w_rd_mux = 8'h00;
    endcase
  end

  avr_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_push    (w_push),
    .i_wr_data (wdata),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_rdata),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // Bus side: register file and one-cycle read pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_udr   <= 8'h00;
      r_ovr   <= 1'b0;
      r_ubrrl <= CLK_DIV[7:0];
      r_ubrrh <= CLK_DIV[15:8];
      r_rdata <= 8'h00;
      r_hit   <= 1'b0;
    end else begin
      r_hit   <= w_in_win;
      r_rdata <= w_in_win ? w_rd_mux : 8'h00;
      if (w_push) begin
        r_udr <= wdata;
      end
      if (w_wr_udr && w_fifo_full) begin
        r_ovr <= 1'b1;
      end else if (w_wr_usr && wdata[USR_OVR_BIT]) begin
        r_ovr <= 1'b0;
      end
      if (w_wr_ubrrl) begin
        r_ubrrl <= wdata;
      end
      if (w_wr_ubrrh) begin
        r_ubrrh <= wdata;
      end
    end
  end

  // Line side: the divisor is latched per frame so bus writes only affect
  // the next frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= TX_IDLE;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (w_pop) begin
            r_shift   <= w_fifo_rdata;
            r_bit_div <= w_ubrr;
            r_cnt     <= w_ubrr;
            r_txd     <= 1'b0;
            r_state   <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_txd   <= r_shift[0];
            r_idx   <= 3'd0;
            r_cnt   <= r_bit_div;
            r_state <= TX_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_cnt <= r_bit_div;
            if (r_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift   <= w_fifo_rdata;
              r_bit_div <= w_ubrr;
              r_cnt     <= w_ubrr;
              r_txd     <= 1'b0;
              r_state   <= TX_START;
            end else begin
              r_state <= TX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign io_rdata = r_rdata;
  assign io_hit   = r_hit;
  assign txd      = r_txd;
  assign tx_irq   = (w_fifo_count == '0) && (r_state == TX_IDLE);

endmodule
